// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-block instruction cache responder. Hits answer combinationally;
// misses fetch the block from memory. The optional ICACHE_STATS_EN macro adds hit/miss counters.
`timescale 1ns/1ps

module icache_responder #(
    parameter  int NSETS = 16,
    localparam int IDXW  = $clog2(NSETS)
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int TAGW = 32 - IDXW - 2;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t            r_state;
    logic [31:0]       r_miss_addr;
    logic [NSETS-1:0]  r_valid;
    logic [TAGW-1:0]   r_tag  [NSETS];
    logic [31:0]       r_data [NSETS];

    logic [IDXW-1:0]   w_idx;
    logic [TAGW-1:0]   w_tag;
    logic [IDXW-1:0]   w_fill_idx;
    logic [TAGW-1:0]   w_fill_tag;
    logic              w_hit;
    logic              w_fill;
    logic              w_unused;

    assign w_idx      = imemaddr[IDXW+1:2];
    assign w_tag      = imemaddr[31:IDXW+2];
    assign w_fill_idx = r_miss_addr[IDXW+1:2];
    assign w_fill_tag = r_miss_addr[31:IDXW+2];
    assign w_unused   = ^imemaddr[1:0];

    assign w_hit  = (r_state == IDLE) && imemREN && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_fill = (r_state == MISS) && !iwait;

    assign ihit     = w_hit;
    assign imemload = w_hit ? r_data[w_idx] : 32'd0;
    assign iREN     = (r_state == MISS);
    assign iaddr    = (r_state == MISS) ? r_miss_addr : 32'd0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_miss_addr <= 32'd0;
            r_valid     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (imemREN && !w_hit) begin
                        r_miss_addr <= imemaddr;
                        r_state     <= MISS;
                    end
                end
                MISS: begin
                    // The fill always targets the latched address, whatever the fetch port does now.
                    if (!iwait) begin
                        r_valid[w_fill_idx] <= 1'b1;
                        r_state             <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Tag/data storage carries no reset; the valid bits alone qualify a frame.
    always_ff @(posedge CLK) begin
        if (w_fill) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_hit_count  <= 32'd0;
            r_miss_count <= 32'd0;
        end else begin
            if (w_hit)
                r_hit_count <= r_hit_count + 32'd1;
            if ((r_state == IDLE) && imemREN && !w_hit)
                r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Testbench for icache_responder: directed scenarios plus a randomized fetch stream checked by a
// scoreboard against an abstract cache model. Counter checks apply when ICACHE_STATS_EN is defined.
`timescale 1ns/1ps

module tb_icache_responder;

    logic        clk;
    logic        rst_n;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache_responder #(.NSETS(16)) dut (
        .CLK      (clk),
        .nRST     (rst_n),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Backing memory contents: a fixed word for 0x40, otherwise a hash of the word address.
    function automatic logic [31:0] memval(input logic [31:0] a);
        logic [31:0] x;
        x = {2'b00, a[31:2]};
        if (x == 32'h10)
            return 32'h2001_0005;
        return (x * 32'h9E37_79B1) ^ 32'hA5C3_0F1E;
    endfunction

    // Memory model: fixed or random latency per miss, garbage on iload while busy.
    int fixed_wait = -1;
    int wait_left  = 0;
    bit in_miss    = 0;

    initial begin
        iwait = 1'b1;
        iload = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            if (iREN === 1'b1) begin
                if (!in_miss) begin
                    in_miss   = 1;
                    wait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 4));
                end
                if (wait_left > 0) begin
                    iwait = 1'b1;
                    iload = $urandom;
                    wait_left--;
                end else begin
                    iwait = 1'b0;
                    iload = memval(iaddr);
                end
            end else begin
                in_miss = 0;
                iwait   = 1'($urandom_range(0, 1));
                iload   = $urandom;
            end
        end
    end

    // Abstract cache model: which word address currently occupies each of the 16 frames.
    bit          ref_valid [16];
    logic [29:0] ref_word  [16];
    int          ref_hits   = 0;
    int          ref_misses = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          hit;
    } exp_t;
    exp_t sb_q[$];
    bit   sb_en   = 0;
    int   mon_cnt = 0;

    // Monitor: one pop per ihit cycle; a hit must arrive on the first request cycle,
    // a miss needs at least the lookup cycle plus one memory cycle first.
    always @(negedge clk) begin
        if (sb_en && rst_n) begin
            if (imemREN) begin
                if (ihit) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_unexpected_hit", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        chk($sformatf("data@%h", e.addr), imemload, e.data);
                        chk($sformatf("latency@%h", e.addr), 32'(mon_cnt >= 2),
                            32'(e.hit ? 1'b0 : 1'b1));
                        if (e.hit)
                            chk($sformatf("hit_first@%h", e.addr), 32'(mon_cnt), 32'd0);
                        chk("iren_on_hit", 32'(iREN), 32'd0);
                    end
                    mon_cnt = 0;
                end else begin
                    mon_cnt++;
                    if (iREN)
                        chk("iaddr_follows", iaddr, imemaddr);
                end
            end else begin
                chk("idle_ihit", 32'(ihit), 32'd0);
                chk("idle_iren", 32'(iREN), 32'd0);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        imemREN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) ref_valid[i] = 0;
        ref_hits   = 0;
        ref_misses = 0;
    endtask

    // Directed fetch: count non-hit cycles before ihit and check the returned word.
    task automatic fetch_d(input logic [31:0] a, input int exp_zero, input string nm);
        int n;
        @(posedge clk);
        #1;
        imemREN  = 1'b1;
        imemaddr = a;
        n = 0;
        forever begin
            @(negedge clk);
            if (ihit) break;
            n++;
            if (n > 100) break;
        end
        chk({nm, "_cycles"}, 32'(n), 32'(exp_zero));
        chk({nm, "_data"}, imemload, memval(a));
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0040;

        // Reset held with a pending fetch
        repeat (3) @(negedge clk);
        chk("rst_ihit", 32'(ihit), 32'd0);
        chk("rst_iren", 32'(iREN), 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        chk("rst_imemload", imemload, 32'd0);

        // Cold miss to 0x40 with three busy cycles
        fixed_wait = 3;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("cold_first_miss", 32'(ihit), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("cold_iren%0d", i), 32'(iREN), 32'd1);
            chk($sformatf("cold_iaddr%0d", i), iaddr, 32'h0000_0040);
            chk($sformatf("cold_ihit%0d", i), 32'(ihit), 32'd0);
        end
        @(negedge clk);
        chk("cold_hit", 32'(ihit), 32'd1);
        chk("cold_data", imemload, 32'h2001_0005);
        chk("cold_iren_done", 32'(iREN), 32'd0);

        // Re-fetch hits in the same cycle; another index misses
        @(negedge clk);
        chk("refetch_hit", 32'(ihit), 32'd1);
        chk("refetch_iren", 32'(iREN), 32'd0);
        fixed_wait = 0;
        fetch_d(32'h0000_0044, 2, "other_idx");

        // Conflict on frame 0
        fixed_wait = 1;
        fetch_d(32'h0000_0080, 3, "conflict_80");
        fetch_d(32'h0000_0040, 3, "conflict_40");
        fetch_d(32'h0000_0040, 0, "conflict_40_hit");

        // Address change during a miss
        fixed_wait = 3;
        @(posedge clk);
        #1;
        imemaddr = 32'h0000_0100;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        imemaddr = 32'h0000_0104;
        @(negedge clk);
        chk("chg_iaddr", iaddr, 32'h0000_0100);
        chk("chg_iren", 32'(iREN), 32'd1);
        n = 0;
        forever begin
            @(negedge clk);
            if (ihit) break;
            n++;
            if (n > 100) break;
        end
        chk("chg_104_fresh_miss", 32'(n >= 3), 32'd1);
        chk("chg_104_data", imemload, memval(32'h0000_0104));
        fetch_d(32'h0000_0100, 0, "chg_100_hit");

`ifdef ICACHE_STATS_EN
        do_reset();
        fixed_wait = 0;
        fetch_d(32'h0000_0300, 2, "st_a_miss");
        fetch_d(32'h0000_0300, 0, "st_a_hit");
        fetch_d(32'h0000_0304, 2, "st_b_miss");
        fetch_d(32'h0000_0304, 0, "st_b_hit");
        fetch_d(32'h0000_0300, 0, "st_a_hit2");
        @(posedge clk);
        #1;
        imemREN = 1'b0;
        @(negedge clk);
        chk("st_hit_count", hit_count, 32'd5);
        chk("st_miss_count", miss_count, 32'd2);
        fixed_wait = 5;
        @(posedge clk);
        #1;
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0500;
        @(negedge clk);
        @(negedge clk);
        chk("st_midmiss_iren", 32'(iREN), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("st_rst_iren", 32'(iREN), 32'd0);
        chk("st_rst_hits", hit_count, 32'd0);
        chk("st_rst_misses", miss_count, 32'd0);
`endif

        // Randomized fetch stream against the model
        do_reset();
        fixed_wait = -1;
        sb_en = 1;
        for (int t = 0; t < 400; t++) begin
            logic [31:0] a;
            logic [25:0] tg;
            int          idx;
            exp_t        e;
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
                imemREN = 1'b0;
                @(negedge clk);
            end
            tg  = ($urandom_range(0, 4) == 4) ? 26'h3FF_FFFF : 26'($urandom_range(0, 3));
            idx = $urandom_range(0, 15);
            a   = {tg, 4'(idx), 2'($urandom_range(0, 3))};
            e.addr = a;
            e.data = memval(a);
            e.hit  = ref_valid[idx] && (ref_word[idx] == a[31:2]);
            if (!e.hit) ref_misses++;
            ref_valid[idx] = 1;
            ref_word[idx]  = a[31:2];
            ref_hits++;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            imemREN  = 1'b1;
            imemaddr = a;
            n = 0;
            forever begin
                @(negedge clk);
                if (ihit) break;
                n++;
                if (n > 100) break;
            end
            if (!ihit) begin
                chk("fetch_timeout", 32'(n), 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        imemREN = 1'b0;
        @(negedge clk);
        sb_en = 0;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
`ifdef ICACHE_STATS_EN
        chk("rand_hit_count", hit_count, 32'(ref_hits));
        chk("rand_miss_count", miss_count, 32'(ref_misses));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
